dmem_mmio: RTL

- Data-side memory stage directly downstream of the single-cycle ARM core.
- Consumes the core's MemWrite, ALUResult (address) and WriteData; returns ReadData.
- Holds word-addressed data RAM plus a small memory-mapped I/O block: LED register, synchronised switch inputs, and a 32-bit timer with compare-match flag and interrupt output.

---
 rtl/dmem_mmio_pkg.sv | 19 +
 rtl/mmio_timer.sv | 64 ++++++
 rtl/dmem_mmio.sv | 96 +++++++++
 3 files changed

// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO stage.
// MMIO offsets are word offsets (byte offset >> 2), compared against a[7:2].
package dmem_mmio_pkg;

  localparam int MMIO_SEL_BIT = 31;

  localparam logic [5:0] OFF_LED    = 6'h00;
  localparam logic [5:0] OFF_SW     = 6'h01;
  localparam logic [5:0] OFF_COUNT  = 6'h02;
  localparam logic [5:0] OFF_CMP    = 6'h03;
  localparam logic [5:0] OFF_STATUS = 6'h04;
  localparam logic [5:0] OFF_CTRL   = 6'h05;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQEN      = 2;
  localparam int CTRL_W          = 3;

endpackage

// File: rtl/mmio_timer.sv
// 32-bit up-counting timer with compare-match flag, auto-reload and interrupt.
module mmio_timer
  import dmem_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        cmp_we,
  input  logic        status_we,
  input  logic        ctrl_we,
  input  logic [31:0] wd,
  output logic [31:0] count_rd,
  output logic [31:0] cmp_rd,
  output logic [31:0] status_rd,
  output logic [31:0] ctrl_rd,
  output logic        irq
);

  logic [31:0]       count_q, count_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              match_q, match_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              match_hit;

  // Compare uses pre-write COUNT and CMP so software writes land a cycle later.
  assign match_hit = ctrl_q[CTRL_EN] && (count_q == cmp_q);

  always_comb begin
    count_d = count_q;
    if (ctrl_q[CTRL_EN]) begin
      if (match_hit && ctrl_q[CTRL_AUTORELOAD]) count_d = 32'h0;
      else                                     count_d = count_q + 32'h1;
    end
    if (count_we) count_d = wd;

    match_d = match_q;
    if (status_we && wd[0]) match_d = 1'b0;
    if (match_hit)          match_d = 1'b1;

    cmp_d  = cmp_we  ? wd             : cmp_q;
    ctrl_d = ctrl_we ? wd[CTRL_W-1:0] : ctrl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 32'h0;
      cmp_q   <= 32'hFFFF_FFFF;
      match_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign count_rd  = count_q;
  assign cmp_rd    = cmp_q;
  assign status_rd = {31'h0, match_q};
  assign ctrl_rd   = {{(32-CTRL_W){1'b0}}, ctrl_q};
  assign irq       = match_q & ctrl_q[CTRL_IRQEN];

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory stage: word RAM plus LED, synchronised switches and timer MMIO.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_WORDS = 64,
  parameter int SW_WIDTH  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [31:0]         a,
  input  logic [31:0]         wd,
  output logic [31:0]         rd,
  input  logic [SW_WIDTH-1:0] sw,
  output logic [SW_WIDTH-1:0] led,
  output logic                irq
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  logic [31:0]         ram_q [RAM_WORDS];
  logic [IDX_W-1:0]    ram_idx;
  logic [5:0]          mmio_off;
  logic                mmio_sel, ram_we, mmio_we;
  logic [SW_WIDTH-1:0] led_q, led_d;
  logic [SW_WIDTH-1:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [31:0]         count_rd, cmp_rd, status_rd, ctrl_rd;
  logic                unused_addr_bits;

  assign mmio_sel = a[MMIO_SEL_BIT];
  assign mmio_off = a[7:2];
  assign ram_idx  = a[IDX_W+1:2];
  assign ram_we   = we & ~mmio_sel;
  assign mmio_we  = we &  mmio_sel;

  // Byte lane and high MMIO address bits are don't-care by design.
  assign unused_addr_bits = ^{a[30:8], a[1:0]};

  // RAM contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= wd;
  end

  always_comb begin
    led_d     = (mmio_we && mmio_off == OFF_LED) ? wd[SW_WIDTH-1:0] : led_q;
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  mmio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .count_we  (mmio_we && mmio_off == OFF_COUNT),
    .cmp_we    (mmio_we && mmio_off == OFF_CMP),
    .status_we (mmio_we && mmio_off == OFF_STATUS),
    .ctrl_we   (mmio_we && mmio_off == OFF_CTRL),
    .wd        (wd),
    .count_rd  (count_rd),
    .cmp_rd    (cmp_rd),
    .status_rd (status_rd),
    .ctrl_rd   (ctrl_rd),
    .irq       (irq)
  );

  always_comb begin
    rd = 32'h0;
    if (!mmio_sel) begin
      rd = ram_q[ram_idx];
    end else begin
      case (mmio_off)
        OFF_LED:    rd[SW_WIDTH-1:0] = led_q;
        OFF_SW:     rd[SW_WIDTH-1:0] = sw_sync_q;
        OFF_COUNT:  rd = count_rd;
        OFF_CMP:    rd = cmp_rd;
        OFF_STATUS: rd = status_rd;
        OFF_CTRL:   rd = ctrl_rd;
        default:    rd = 32'h0;
      endcase
    end
  end

  assign led = led_q;

endmodule
